board_painter: RTL and testbench

Consumes the falling-piece state produced by the game-logic block (current and previous square coordinates, piece colour, row-clear command) and turns it into write traffic on the board colour RAM read by the VGA colour mapper. Once per frame tick it shifts rows down for a clear, erases the piece's previous squares and paints its current squares. It sits between game logic and the dual-port board RAM, owning that RAM's write port and one read port.

---
 rtl/board_painter_pkg.sv | 29 ++
 rtl/board_painter_if.sv | 14 +
 rtl/board_painter_frame_tick_sync.sv | 22 ++
 rtl/board_painter.sv | 164 ++++++++++++++++
 tb/tb_board_painter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/board_painter_pkg.sv
// Board geometry, colour width, painter state encoding and cell addressing.
// Shared by the game logic, the board painter and the colour mapper.
package board_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ADDR_W  = 8;
  localparam int COLOR_W = 16;

  typedef logic [6:0]      coord_t;
  typedef logic [3:0][6:0] piece_t;

  localparam coord_t X_LIM = coord_t'(BOARD_W);
  localparam coord_t Y_LIM = coord_t'(BOARD_H);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_RD,
    SHIFT_WR,
    ERASE,
    DRAW,
    DONE
  } paint_state_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input coord_t x, input coord_t y);
    return ADDR_W'(y) * ADDR_W'(BOARD_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/board_painter_if.sv
// Board RAM port owned by the painter: one synchronous read port and the write port.
interface board_painter_if;
  import board_pkg::*;

  logic [ADDR_W-1:0]  rd_addr;
  logic [COLOR_W-1:0] rd_data;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);

endinterface

// File: rtl/board_painter_frame_tick_sync.sv
// Brings the asynchronous frame clock into Clk and emits a one-cycle tick per rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick_o
);

  // [0] and [1] form the synchroniser, [2] holds the previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
    end
  end

  assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/board_painter.sv
// Per-frame board RAM writer: optional row shift for a clear, then erase of the
// previous piece squares and paint of the current ones, from an input snapshot.
module board_painter
  import board_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  piece_t             blockXPos,
  input  piece_t             blockYPos,
  input  piece_t             blockXPrev,
  input  piece_t             blockYPrev,
  input  logic [COLOR_W-1:0] blockColor,
  input  logic               Clear_row,
  input  logic [3:0]         Num_rows_to_clear,
  input  coord_t             Row_to_clear,
  board_painter_if.master    ram,
  output logic               busy,
  output logic               overrun
);

  localparam logic [3:0] X_LAST = 4'(BOARD_W - 1);

  paint_state_e       state_q, start_state;
  piece_t             xpos_q, ypos_q, xprev_q, yprev_q;
  logic [COLOR_W-1:0] color_q;
  logic [3:0]         nclr_q;
  coord_t             row_q;
  logic [3:0]         x_q;
  logic [1:0]         i_q;
  logic               pending_q, overrun_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COLOR_W-1:0] wr_data_q;

  logic   tick, start;
  coord_t nclr_ext, x_ext, ex, ey, dx, dy;
  logic   src_ok, next_row_src_ok, prev_none, erase_hit, erase_skip, draw_ok;

  frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick_o    (tick)
  );

  assign nclr_ext        = {3'b000, nclr_q};
  assign x_ext           = {3'b000, x_q};
  assign src_ok          = row_q >= nclr_ext;
  assign next_row_src_ok = (row_q - 7'd1) >= nclr_ext;

  assign ex = xprev_q[i_q];
  assign ey = yprev_q[i_q];
  assign dx = xpos_q[i_q];
  assign dy = ypos_q[i_q];

  assign prev_none  = (xprev_q == '0) && (yprev_q == '0);
  assign erase_skip = prev_none || erase_hit || (ex >= X_LIM) || (ey >= Y_LIM);
  assign draw_ok    = (dx < X_LIM) && (dy < Y_LIM);

  always_comb begin
    erase_hit = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (xpos_q[j] == ex && ypos_q[j] == ey) erase_hit = 1'b1;
    end
  end

  // First state of a job; rows that would source from above the top fill blank without a read
  always_comb begin
    start_state = ERASE;
    if (Clear_row && Num_rows_to_clear != 4'd0 && Row_to_clear < Y_LIM) begin
      start_state = (Row_to_clear >= {3'b000, Num_rows_to_clear}) ? SHIFT_RD : SHIFT_WR;
    end
  end

  assign start = (state_q == IDLE && tick) || (state_q == DONE && (tick || pending_q));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      xpos_q    <= '0;
      ypos_q    <= '0;
      xprev_q   <= '0;
      yprev_q   <= '0;
      color_q   <= '0;
      nclr_q    <= '0;
      row_q     <= '0;
      x_q       <= '0;
      i_q       <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (tick && state_q != IDLE && state_q != DONE) begin
        if (pending_q) overrun_q <= 1'b1;
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: ;
        SHIFT_RD: state_q <= SHIFT_WR;
        SHIFT_WR: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cell_addr(x_ext, row_q);
          wr_data_q <= src_ok ? ram.rd_data : '0;
          if (x_q == X_LAST) begin
            x_q <= '0;
            if (row_q == '0) begin
              i_q     <= '0;
              state_q <= ERASE;
            end else begin
              row_q   <= row_q - 7'd1;
              state_q <= next_row_src_ok ? SHIFT_RD : SHIFT_WR;
            end
          end else begin
            x_q     <= x_q + 4'd1;
            state_q <= src_ok ? SHIFT_RD : SHIFT_WR;
          end
        end
        ERASE: begin
          wr_en_q   <= ~erase_skip;
          wr_addr_q <= cell_addr(ex, ey);
          wr_data_q <= '0;
          i_q       <= i_q + 2'd1;
          if (i_q == 2'd3) state_q <= DRAW;
        end
        DRAW: begin
          wr_en_q   <= draw_ok;
          wr_addr_q <= cell_addr(dx, dy);
          wr_data_q <= color_q;
          i_q       <= i_q + 2'd1;
          if (i_q == 2'd3) state_q <= DONE;
        end
        DONE: begin
          pending_q <= pending_q & tick;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (start) begin
        xpos_q  <= blockXPos;
        ypos_q  <= blockYPos;
        xprev_q <= blockXPrev;
        yprev_q <= blockYPrev;
        color_q <= blockColor;
        nclr_q  <= Num_rows_to_clear;
        row_q   <= Row_to_clear;
        x_q     <= '0;
        i_q     <= '0;
        state_q <= start_state;
      end
    end
  end

  assign ram.rd_addr = (state_q == SHIFT_RD) ? cell_addr(x_ext, row_q - nclr_ext) : '0;
  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_board_painter.sv
// Scoreboard bench for board_painter: a behavioural board RAM plus a reference
// painter model that queues expected writes as each frame job is launched.
module tb_board_painter;
  import board_pkg::*;

  logic   Clk = 1'b0;
  logic   Reset_n = 1'b0;
  logic   frame_clk = 1'b0;
  piece_t bx, by, bxp, byp;
  logic [15:0] col;
  logic   clr;
  logic [3:0] nclr;
  coord_t rclr;
  logic   busy, overrun;

  board_painter_if ram ();

  board_painter dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .frame_clk         (frame_clk),
    .blockXPos         (bx),
    .blockYPos         (by),
    .blockXPrev        (bxp),
    .blockYPrev        (byp),
    .blockColor        (col),
    .Clear_row         (clr),
    .Num_rows_to_clear (nclr),
    .Row_to_clear      (rclr),
    .ram               (ram),
    .busy              (busy),
    .overrun           (overrun)
  );

  always #5 Clk = ~Clk;

  logic [15:0] mem [0:255];
  logic [15:0] mm  [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge Clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram.wr_en) mem[ram.wr_addr] <= ram.wr_data;
    ram.rd_data <= mem[ram.rd_addr];
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_wr = 0, first_wr = -1;
  logic [31:0] q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clk);
      if (ram.wr_en) begin
        e = (q.size() != 0) ? q.pop_front() : 32'hFFFF_FFFF;
        check("wr", {8'h00, ram.wr_addr, ram.wr_data}, e);
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
      end
    end
  end

  task automatic push(input int a, input logic [15:0] d);
    q.push_back({8'h00, 8'(a), d});
    mm[a] = d;
  endtask

  task automatic model_job();
    logic allz, hit;
    int xp, yp;
    if (clr && nclr != 4'd0 && int'(rclr) < 20)
      for (int r = int'(rclr); r >= 0; r--)
        for (int x = 0; x < 10; x++)
          push(r * 10 + x, (r >= int'(nclr)) ? mm[(r - int'(nclr)) * 10 + x] : 16'h0000);
    allz = (bxp == '0) && (byp == '0);
    for (int i = 0; i < 4; i++) begin
      xp = int'(bxp[i]);
      yp = int'(byp[i]);
      hit = 1'b0;
      for (int j = 0; j < 4; j++) if (bx[j] == bxp[i] && by[j] == byp[i]) hit = 1'b1;
      if (!allz && !hit && xp < 10 && yp < 20) push(yp * 10 + xp, 16'h0000);
    end
    for (int i = 0; i < 4; i++)
      if (int'(bx[i]) < 10 && int'(by[i]) < 20) push(int'(by[i]) * 10 + int'(bx[i]), col);
  endtask

  task automatic set_cur(input int x0, y0, x1, y1, x2, y2, x3, y3);
    bxp = bx;
    byp = by;
    bx[0] = 7'(x0); by[0] = 7'(y0);
    bx[1] = 7'(x1); by[1] = 7'(y1);
    bx[2] = 7'(x2); by[2] = 7'(y2);
    bx[3] = 7'(x3); by[3] = 7'(y3);
  endtask

  // frame_clk rises just after edge t0; busy should follow the snapshot at edge t0+3
  task automatic tick(output int t0, output logic b_early);
    @(posedge Clk);
    #1 frame_clk = 1'b1;
    t0 = cyc;
    repeat (2) @(posedge Clk);
    #1 b_early = busy;
    @(posedge Clk);
    #1 frame_clk = 1'b0;
  endtask

  task automatic wait_done(output int t_end);
    t_end = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge Clk);
      if (!busy) begin
        t_end = cyc;
        break;
      end
    end
    check("job_end_busy", 32'(busy), 32'd0);
  endtask

  int t0, t1, t_end, w0;
  logic b_early;

  initial begin
    bx = '0; by = '0; bxp = '0; byp = '0;
    col = 16'h0f00; clr = 1'b0; nclr = 4'd0; rclr = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_wr_en",   32'(ram.wr_en),   32'd0);
    check("rst_wr_addr", 32'(ram.wr_addr), 32'd0);
    check("rst_wr_data", 32'(ram.wr_data), 32'd0);
    check("rst_rd_addr", 32'(ram.rd_addr), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_overrun", 32'(overrun),     32'd0);
    Reset_n = 1'b1;

    for (int a = 0; a < 200; a++) begin
      @(negedge Clk);
      pl_we = 1'b1;
      pl_addr = 8'(a);
      pl_data = 16'($urandom);
      mm[a] = pl_data;
    end
    @(negedge Clk);
    pl_we = 1'b0;

    // draw only: no previous squares
    set_cur(4, 0, 4, 1, 5, 1, 5, 2);
    bxp = '0; byp = '0;
    model_job();
    first_wr = -1; w0 = n_wr;
    tick(t0, b_early);
    check("draw_busy_early", 32'(b_early), 32'd0);
    check("draw_busy_rise",  32'(busy),    32'd1);
    wait_done(t_end);
    check("draw_busy_len", 32'(t_end - (t0 + 3)), 32'd9);
    check("draw_first_wr", 32'(first_wr - t0),    32'd8);
    check("draw_n_wr",     32'(n_wr - w0),        32'd4);
    check("draw_q_empty",  32'(q.size()),         32'd0);

    // move down: overlapping squares are not erased
    set_cur(4, 1, 4, 2, 5, 2, 5, 3);
    col = 16'h00f0;
    model_job();
    first_wr = -1; w0 = n_wr;
    tick(t0, b_early);
    wait_done(t_end);
    check("move_first_wr", 32'(first_wr - t0), 32'd4);
    check("move_n_wr",     32'(n_wr - w0),     32'd6);
    check("move_q_empty",  32'(q.size()),      32'd0);

    // out-of-range current squares are skipped
    set_cur(10, 3, 2, 20, 3, 3, 3, 4);
    col = 16'h000f;
    model_job();
    w0 = n_wr;
    tick(t0, b_early);
    wait_done(t_end);
    check("oor_n_wr",    32'(n_wr - w0), 32'd6);
    check("oor_q_empty", 32'(q.size()),  32'd0);

    // clear row 18 by one
    set_cur(0, 5, 1, 5, 2, 5, 1, 6);
    col = 16'h1234; clr = 1'b1; rclr = 7'd18; nclr = 4'd1;
    model_job();
    tick(t0, b_early);
    wait_done(t_end);
    check("clr_busy_len",  32'(t_end - (t0 + 3)), 32'd379);
    check("clr_q_empty",   32'(q.size()),         32'd0);
    check("clr_row18_x3",  32'(mem[183]),         32'(mm[183]));
    check("clr_row0_x9",   32'(mem[9]),           32'd0);
    check("clr_overrun",   32'(overrun),          32'd0);

    // two extra ticks during a clear: one queued job, one dropped
    set_cur(6, 0, 7, 0, 8, 0, 7, 1);
    col = 16'h0abc;
    model_job();
    tick(t0, b_early);
    repeat (30) @(posedge Clk);
    set_cur(6, 1, 7, 1, 8, 1, 7, 2);
    clr = 1'b0; col = 16'h0def;
    model_job();
    tick(t1, b_early);
    check("ovr_after_pend", 32'(overrun), 32'd0);
    repeat (30) @(posedge Clk);
    tick(t1, b_early);
    wait_done(t_end);
    check("ovr_busy_len", 32'(t_end - (t0 + 3)), 32'd388);
    check("ovr_set",      32'(overrun),          32'd1);
    check("ovr_q_empty",  32'(q.size()),         32'd0);

    set_cur(6, 2, 7, 2, 8, 2, 7, 3);
    model_job();
    tick(t0, b_early);
    wait_done(t_end);
    check("ovr_sticky",  32'(overrun),  32'd1);
    check("post_q_empty", 32'(q.size()), 32'd0);

    // reset during the shift phase
    set_cur(1, 8, 2, 8, 3, 8, 2, 9);
    clr = 1'b1; rclr = 7'd18; nclr = 4'd1;
    model_job();
    tick(t0, b_early);
    repeat (50) @(posedge Clk);
    #1 Reset_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_wr_en",   32'(ram.wr_en), 32'd0);
    check("mid_rst_busy",    32'(busy),      32'd0);
    check("mid_rst_overrun", 32'(overrun),   32'd0);
    check("mid_rst_rd_addr", 32'(ram.rd_addr), 32'd0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    w0 = n_wr;
    repeat (60) @(posedge Clk);
    #1;
    check("post_rst_no_wr", 32'(n_wr - w0), 32'd0);
    check("post_rst_busy",  32'(busy),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
